// File: rtl/uart_pkg.sv
// Shared UART definitions: sequencer state encoding (TX and RX), default
// frame geometry and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: bit_end strobes combinationally on the tick that completes a bit.
// A synchronous clear loads PRELOAD; RX uses a half-bit preload to sample mid-bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PRELOAD    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] tick_cnt;

  assign bit_end = tick && (tick_cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= CW'(PRELOAD);
    end else if (bit_end) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_seq.sv
// UART TX bit sequencer: start, LSB-first data, optional even parity (UART_TX_PARITY_EN), stop.
// tx/busy respond one edge after start in IDLE; start is ignored while busy, no queuing.
module uart_tx_seq
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = $clog2(DATA_BITS);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_cnt;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  // Holding the timer cleared in IDLE keeps a tick coincident with start out of the start bit.
  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE),
    .PRELOAD   (0)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .tick   (tick),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= IDLE_LVL;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift   <= tx_data;
            bit_cnt <= '0;
            tx      <= START_LVL;
            busy    <= 1'b1;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            par     <= ^tx_data;
`endif
          end else begin
            tx   <= IDLE_LVL;
            busy <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= par;
              state   <= PARITY;
`else
              tx      <= IDLE_LVL;
              state   <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= IDLE_LVL;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          tx <= IDLE_LVL;
          if (bit_end) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx    <= IDLE_LVL;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: table of frames plus hand-written corner sequences, with a
// tick-counting monitor that pops expected line levels from a scoreboard queue.
module tb_uart_tx_seq;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [7:0] tx_data;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  int   frames_pending = 0;
  bit   in_frame = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // {stop, data msb..lsb, start}; bit 0 goes out first
    logic       par;
    bit         align;   // launch start in a cycle that also carries a tick
  } vec_t;

  vec_t vecs[5];

  uart_tx_seq #(
    .OVERSAMPLE(OS),
    .DATA_BITS (8),
    .STOP_BITS (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .start  (start),
    .tx_data(tx_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      div  = (div + 1) % 4;
      tick = (div == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts ticks consumed by the DUT while a frame is in flight and checks
  // that each bit appears on the edge ending the previous bit and holds through its 16th tick.
  initial begin
    int   cnt;
    logic t;
    logic cur;
    logic prev_done;
    cnt       = 0;
    cur       = 1'b1;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      t = tick;
      #1;
      if (!rst) begin
        in_frame  = 0;
        cnt       = 0;
        prev_done = 1'b0;
        continue;
      end
      if (prev_done) chk("done_width", done, 1'b0);
      prev_done = done;
      if (!in_frame) begin
        if (busy) begin
          chk("frame_expected", (frames_pending > 0 && exp_q.size() > 0), 1'b1);
          in_frame = 1;
          cnt      = 0;
          if (frames_pending > 0 && exp_q.size() > 0) begin
            frames_pending--;
            cur = exp_q.pop_front();
            chk("start_bit", tx, cur);
          end
        end else if (done) begin
          chk("spurious_done", done, 1'b0);
        end
      end else begin
        if (t) cnt++;
        if (t && cnt == FRAME_BITS * OS) begin
          chk("done_at_end", done, 1'b1);
          chk("busy_at_end", busy, 1'b0);
          chk("tx_idle_at_end", tx, 1'b1);
          in_frame = 0;
        end else begin
          if (done) chk("early_done", done, 1'b0);
          if (!busy) chk("busy_held", busy, 1'b1);
          if (t && (cnt % OS) == 0) begin
            chk("bit_available", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            chk("tx_bit", tx, cur);
          end else if (t && (cnt % OS) == OS - 1) begin
            chk("tx_hold", tx, cur);
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [9:0] fr, input logic p);
    for (int i = 0; i < 9; i++) exp_q.push_back(fr[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(p);
`else
    if (p === 1'bx) exp_q.push_back(1'b0);
`endif
    exp_q.push_back(fr[9]);
    frames_pending++;
  endtask

  task automatic send(input logic [7:0] d, input logic [9:0] fr, input logic p, input bit align);
    if (align) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        #1;
        if (tick) break;
      end
    end else begin
      @(negedge clk);
    end
    start   = 1'b1;
    tx_data = d;
    push_frame(fr, p);
    @(negedge clk);
    start   = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (!busy && !in_frame && frames_pending == 0) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle_timeout", ok, 1'b1);
  endtask

  initial begin
    bit found;
    bit done_seen;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 10'b1000001110, 1'b1, 1'b1};

    rst     = 1'b0;
    start   = 1'b0;
    tx_data = 8'h00;

    // Reset held with random stimulus
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start   = 1'($urandom);
      tx_data = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_tx", tx, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].data, vecs[v].frame, vecs[v].par, vecs[v].align);
      wait_idle();
    end

    // Start while busy is ignored
    send(8'hA5, vecs[0].frame, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    start   = 1'b1;
    tx_data = 8'h3C;
    repeat (20) @(negedge clk);
    start   = 1'b0;
    wait_idle();
    repeat (60) @(posedge clk);
    #1;
    chk("no_second_frame", busy, 1'b0);

    // Back-to-back: second start asserted during done
    send(8'h00, vecs[1].frame, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        found = 1;
        break;
      end
    end
    chk("b2b_done_seen", found, 1'b1);
    start   = 1'b1;
    tx_data = 8'hFF;
    push_frame(vecs[2].frame, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy_next_edge", busy, 1'b1);
    chk("b2b_tx_start_next_edge", tx, 1'b0);
    wait_idle();

    // Reset during data bit 3 aborts the frame
    send(8'hA5, vecs[0].frame, 1'b0, 1'b0);
    repeat (280) @(negedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    frames_pending = 0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen = 1;
    end
    chk("abort_no_done", done_seen, 1'b0);
    send(8'h3C, vecs[3].frame, 1'b0, 1'b0);
    wait_idle();

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_seq.md
# uart_tx_seq

UART transmit bit sequencer, driven by the shared oversample tick (16x baud). It accepts one data word per handshake and serialises it LSB-first as start, data, optional parity and stop bits. Each bit is held for exactly OVERSAMPLE tick pulses, counted internally. It sits between the baud tick generator and the TX pin, and is the control counterpart of the RX path.

## Interface
- OVERSAMPLE, 16, tick pulses per serial bit; legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  oversample tick; single-cycle pulse from the baud divider.
- start  input  1  transmit request; sampled only while idle.
- tx_data  input  DATA_BITS  word to send; latched on acceptance.
- tx  output  1  serial line; idles high.
- busy  output  1  high from acceptance to frame end.
- done  output  1  one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY exists only when the macro is defined.
- **Registers:**
  - tick_cnt: width $clog2(OVERSAMPLE).
  - bit_cnt: width $clog2(DATA_BITS) or wider, enough to hold STOP_BITS−1.
  - shift register: DATA_BITS wide.
  - tx, busy and done are all registered.
- **Bit-end condition:** the cycle in which tick=1 and tick_cnt=OVERSAMPLE−1.
  - On that cycle tick_cnt wraps to 0 and the FSM advances.
  - On any other tick, tick_cnt increments.
  - Without a tick, tick_cnt holds.
- **IDLE:**
  - start=1 → latch tx_data, set tx=0, set busy=1, clear tick_cnt and bit_cnt, go to START.
  - start=0 → tx=1, busy=0.
- **START:** at bit-end, go to DATA and drive tx=shift[0].
- **DATA:**
  - At bit-end, shift right and increment bit_cnt.
  - After bit DATA_BITS−1, go to PARITY or STOP, drive tx accordingly and clear bit_cnt.
- **PARITY:** drive the even-parity bit (XOR of the latched word); at bit-end, go to STOP.
- **STOP:**
  - tx=1.
  - At the bit-end of the last stop bit, go to IDLE, set busy=0 and done=1.
- done returns to 0 on the following cycle.
- start is ignored while busy=1. There is no queuing.
- tx_data changes after acceptance do not affect the frame in flight.

## Timing
- Reset values: tx=1, busy=0, done=0, state=IDLE, all counters 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately: tx=1, and no done pulse is produced.
- Acceptance latency: tx falls and busy rises on the clock edge after start is seen in IDLE.
- The start bit lasts exactly OVERSAMPLE ticks measured from acceptance. tick_cnt is cleared at acceptance, so wall-clock phase follows tick arrival.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) × OVERSAMPLE ticks, where P=1 with the macro and P=0 without.
- done and busy=0 appear on the same edge as the final bit-end.
- **Back-to-back frames:**
  - start held high, or asserted while done=1, is accepted on that cycle because the state is already IDLE.
  - The next start bit follows with no idle bit in between.
- If tick and start coincide in IDLE, the tick is not counted toward the new start bit.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in and an even-parity bit is sent between the last data bit and stop.
- UART_TX_PARITY_EN undefined: there is no PARITY state, and DATA goes directly to STOP.

## Structure
- **Shared package uart_pkg:**
  - FSM state encoding, shared with the RX sequencer.
  - Default constants: OVERSAMPLE_DEF=16, DATA_BITS_DEF=8.
  - Line level constants: IDLE_LVL=1, START_LVL=0.
- **Sub-module uart_bit_timer:**
  - Counts tick pulses with a synchronous clear and outputs a bit_end strobe.
  - Parameterised by OVERSAMPLE.
  - Reused by the RX path with a half-bit preload.

## Test plan
Benches use OVERSAMPLE=16, DATA_BITS=8, STOP_BITS=1, and tick every 4 clk.
- **Reset:** hold rst low, with random start and tx_data → tx=1, busy=0, done=0. After release, remain idle until start.
- **Single frame:** send 0xA5 → tx shows 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 16 ticks. done pulses for one cycle 160 ticks after acceptance, and busy falls on the same edge.
- **Start while busy:** assert start with 0x3C mid-frame of 0xA5 → ignored. The 0xA5 frame is unchanged, and there is no second frame.
- **Back-to-back:** send 0x00, then 0xFF with start asserted during done → the second start bit begins on the edge after done, with no idle gap. Total time is 320 ticks.
- **Reset mid-frame:** assert rst during data bit 3 → tx=1 and busy=0 asynchronously, and no done pulse. A new frame after release is correct.
- **Parity (UART_TX_PARITY_EN defined):** 0xA5 → parity bit 0, and 0x07 → parity bit 1. The frame is 176 ticks.
